// File: rtl/convclk_grayffrd.sv
// convclk_grayffrd -- read-side controller of a dual-clock Gray-pointer FIFO.
//
// Lives entirely in the rdclk domain. Brings the write-domain Gray write
// pointer across with a two-flop synchronizer, decodes it to binary and
// derives empty / fill level against the local binary read pointer. Issues
// qualified RAM reads, advances the read pointer, publishes the read pointer
// in Gray code for the write domain, and delays each read by the RAM latency
// to form a data-valid strobe.
//
// Ports:
//   rdclk       read clock, all logic on the rising edge
//   rdrst_      synchronous active-low reset
//   fiford      read request from the consumer
//   fifoflush   synchronous flush of the read pointer and the valid pipe
//   fifoempty   no readable entry
//   notempty    inverse of fifoempty
//   half_full   fill level >= 2^(ADDRB-1)
//   rdfifolen   fill level as seen from the read domain (0 .. 2^ADDRB)
//   read        RAM read enable (request qualified by not-empty, not-flush)
//   rdaddr      RAM read address
//   rdvld       RAM data valid, RDLAT cycles after read
//   rdpnt_gray  registered Gray read pointer, to be synchronized in wrclk
//   wrpnt_gray  Gray write pointer from the wrclk domain (asynchronous)
module convclk_grayffrd #(
    parameter int ADDRB = 4,
    parameter int FSHW  = 2,
    parameter int RDLAT = 1
) (
    input  logic             rdclk,
    input  logic             rdrst_,
    input  logic             fiford,
    input  logic             fifoflush,
    output logic             fifoempty,
    output logic             notempty,
    output logic             half_full,
    output logic [ADDRB:0]   rdfifolen,
    output logic             read,
    output logic [ADDRB-1:0] rdaddr,
    output logic             rdvld,
    output logic [ADDRB:0]   rdpnt_gray,
    input  logic [ADDRB:0]   wrpnt_gray
);

    logic [ADDRB:0]   wrpnt_gray1;
    logic [ADDRB:0]   wrpnt_gray2;
    logic [ADDRB:0]   wrpnt_bin_n;
    logic [ADDRB:0]   wrpnt_bin;
    logic [ADDRB:0]   rdpnt_bin;
    logic [RDLAT-1:0] vld_p;

    function automatic logic [ADDRB:0] gray_to_bin(input logic [ADDRB:0] g);
        logic [ADDRB:0] b;
        b[ADDRB] = g[ADDRB];
        for (int i = ADDRB - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ADDRB:0] bin_to_gray(input logic [ADDRB:0] b);
        return b ^ (b >> 1);
    endfunction

    // Stage: two-flop synchronizer for the asynchronous write pointer.
    // Flush deliberately leaves these alone; the write side owns that pointer.
    always_ff @(posedge rdclk) begin
        if (!rdrst_) begin
            wrpnt_gray1 <= '0;
            wrpnt_gray2 <= '0;
        end else begin
            wrpnt_gray1 <= wrpnt_gray;
            wrpnt_gray2 <= wrpnt_gray1;
        end
    end

    assign wrpnt_bin_n = gray_to_bin(wrpnt_gray2);

    // Stage: optional register after the Gray decode to cut the
    // XOR-chain + subtract path, at the cost of one cycle of latency.
    generate
        if (FSHW == 3) begin : g_bin_reg
            always_ff @(posedge rdclk) begin
                if (!rdrst_) begin
                    wrpnt_bin <= '0;
                end else begin
                    wrpnt_bin <= wrpnt_bin_n;
                end
            end
        end else begin : g_bin_comb
            assign wrpnt_bin = wrpnt_bin_n;
        end
    endgenerate

    // Full compare including the wrap bit: equal means empty, while equal
    // low bits with differing wrap bits means full.
    assign fifoempty = (wrpnt_bin == rdpnt_bin);
    assign notempty  = ~fifoempty;
    assign rdfifolen = wrpnt_bin - rdpnt_bin;
    assign half_full = rdfifolen[ADDRB] | rdfifolen[ADDRB-1];
    assign read      = fiford & ~fifoempty & ~fifoflush;
    assign rdaddr    = rdpnt_bin[ADDRB-1:0];
    assign rdvld     = vld_p[RDLAT-1];

    // Stage: read pointer; flush outranks read.
    always_ff @(posedge rdclk) begin
        if (!rdrst_) begin
            rdpnt_bin <= '0;
        end else if (fifoflush) begin
            rdpnt_bin <= '0;
        end else if (read) begin
            rdpnt_bin <= rdpnt_bin + {{ADDRB{1'b0}}, 1'b1};
        end
    end

    // Stage: Gray export, registered so the write domain never samples
    // combinational glitches from the encoder.
    always_ff @(posedge rdclk) begin
        if (!rdrst_) begin
            rdpnt_gray <= '0;
        end else begin
            rdpnt_gray <= bin_to_gray(rdpnt_bin);
        end
    end

    // Stage: RAM latency tracker; every stage is cleared so no stale
    // valid can emerge after a reset or flush.
    always_ff @(posedge rdclk) begin
        if (!rdrst_ || fifoflush) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= read;
            for (int i = 1; i < RDLAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

endmodule

// File: tb/tb_convclk_grayffrd.sv
module tb_convclk_grayffrd;

    localparam int AW = 4;

    logic          rdclk = 1'b0;
    logic          rdrst_;
    logic          fiford;
    logic          fifoflush;
    logic [AW:0]   wrpnt_gray;

    // Instance A: FSHW=2, RDLAT=1
    logic          a_empty, a_notempty, a_half, a_read, a_rdvld;
    logic [AW:0]   a_len, a_rgray;
    logic [AW-1:0] a_addr;

    // Instance B: FSHW=2, RDLAT=3 (shares A's stimulus)
    logic          b_empty, b_notempty, b_half, b_read, b_rdvld;
    logic [AW:0]   b_len, b_rgray;
    logic [AW-1:0] b_addr;

    // Instance C: FSHW=3, RDLAT=1 (own stimulus)
    logic          c_rst_, c_fiford, c_flush;
    logic [AW:0]   c_wgray;
    logic          c_empty, c_notempty, c_half, c_read, c_rdvld;
    logic [AW:0]   c_len, c_rgray;
    logic [AW-1:0] c_addr;

    int checks = 0;
    int errors = 0;

    always #5 rdclk = ~rdclk;

    convclk_grayffrd #(.ADDRB(AW), .FSHW(2), .RDLAT(1)) dut_a (
        .rdclk(rdclk), .rdrst_(rdrst_), .fiford(fiford), .fifoflush(fifoflush),
        .fifoempty(a_empty), .notempty(a_notempty), .half_full(a_half),
        .rdfifolen(a_len), .read(a_read), .rdaddr(a_addr), .rdvld(a_rdvld),
        .rdpnt_gray(a_rgray), .wrpnt_gray(wrpnt_gray)
    );

    convclk_grayffrd #(.ADDRB(AW), .FSHW(2), .RDLAT(3)) dut_b (
        .rdclk(rdclk), .rdrst_(rdrst_), .fiford(fiford), .fifoflush(fifoflush),
        .fifoempty(b_empty), .notempty(b_notempty), .half_full(b_half),
        .rdfifolen(b_len), .read(b_read), .rdaddr(b_addr), .rdvld(b_rdvld),
        .rdpnt_gray(b_rgray), .wrpnt_gray(wrpnt_gray)
    );

    convclk_grayffrd #(.ADDRB(AW), .FSHW(3), .RDLAT(1)) dut_c (
        .rdclk(rdclk), .rdrst_(c_rst_), .fiford(c_fiford), .fifoflush(c_flush),
        .fifoempty(c_empty), .notempty(c_notempty), .half_full(c_half),
        .rdfifolen(c_len), .read(c_read), .rdaddr(c_addr), .rdvld(c_rdvld),
        .rdpnt_gray(c_rgray), .wrpnt_gray(c_wgray)
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge rdclk);
            #1;
        end
    endtask

    // Vector layout for A: {empty, notempty, half, read, rdvld, len[4:0], addr[3:0], rgray[4:0]}
    task automatic test_reset;
        rdrst_ = 1'b0; fiford = 1'b1; fifoflush = 1'b0; wrpnt_gray = 5'b00000;
        c_rst_ = 1'b0; c_fiford = 1'b1; c_flush = 1'b0; c_wgray = 5'b00000;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checks++;
            if ({a_empty, a_notempty, a_half, a_read, a_rdvld, a_len, a_addr, a_rgray}
                !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 5'd0}) begin
                errors++;
                $display("FAIL reset_a cyc%0d got e%b ne%b h%b r%b v%b len%0d addr%0d g%b", k,
                         a_empty, a_notempty, a_half, a_read, a_rdvld, a_len, a_addr, a_rgray);
            end
            checks++;
            if ({b_empty, b_read, b_rdvld, b_rgray, c_empty, c_read, c_rdvld, c_rgray}
                !== {3'b100, 5'd0, 3'b100, 5'd0}) begin
                errors++;
                $display("FAIL reset_bc cyc%0d got b:%b%b%b %b c:%b%b%b %b required 100 00000 100 00000", k,
                         b_empty, b_read, b_rdvld, b_rgray, c_empty, c_read, c_rdvld, c_rgray);
            end
        end
        fiford = 1'b0; c_fiford = 1'b0;
        rdrst_ = 1'b1; c_rst_ = 1'b1;
        tick(1);
    endtask

    task automatic test_basic_read;
        fiford = 1'b1;
        wrpnt_gray = 5'b00011;          // binary 2
        tick(1);
        checks++;
        if ({a_empty, a_read} !== 2'b10) begin
            errors++;
            $display("FAIL basic_edge1 got empty=%b read=%b required empty=1 read=0", a_empty, a_read);
        end
        tick(1);
        checks++;
        if ({a_empty, a_notempty, a_len, a_read, a_addr, a_rdvld, a_rgray}
            !== {1'b0, 1'b1, 5'd2, 1'b1, 4'd0, 1'b0, 5'b00000}) begin
            errors++;
            $display("FAIL basic_edge2 got e%b ne%b len%0d r%b addr%0d v%b g%b required e0 ne1 len2 r1 addr0 v0 g00000",
                     a_empty, a_notempty, a_len, a_read, a_addr, a_rdvld, a_rgray);
        end
        tick(1);
        checks++;
        if ({a_empty, a_len, a_read, a_addr, a_rdvld, a_rgray}
            !== {1'b0, 5'd1, 1'b1, 4'd1, 1'b1, 5'b00000}) begin
            errors++;
            $display("FAIL basic_edge3 got e%b len%0d r%b addr%0d v%b g%b required e0 len1 r1 addr1 v1 g00000",
                     a_empty, a_len, a_read, a_addr, a_rdvld, a_rgray);
        end
        tick(1);
        checks++;
        if ({a_empty, a_len, a_read, a_addr, a_rdvld, a_rgray}
            !== {1'b1, 5'd0, 1'b0, 4'd2, 1'b1, 5'b00001}) begin
            errors++;
            $display("FAIL basic_edge4 got e%b len%0d r%b addr%0d v%b g%b required e1 len0 r0 addr2 v1 g00001",
                     a_empty, a_len, a_read, a_addr, a_rdvld, a_rgray);
        end
        tick(1);
        checks++;
        if ({a_empty, a_read, a_rdvld, a_rgray} !== {3'b100, 5'b00011}) begin
            errors++;
            $display("FAIL basic_edge5 got e%b r%b v%b g%b required e1 r0 v0 g00011 (fiford ignored while empty)",
                     a_empty, a_read, a_rdvld, a_rgray);
        end
        fiford = 1'b0;
    endtask

    task automatic test_half_full;
        fifoflush = 1'b1;
        wrpnt_gray = 5'b11000;          // binary 16
        tick(1);
        fifoflush = 1'b0;
        tick(1);
        checks++;
        if ({a_empty, a_len, a_half, a_addr} !== {1'b0, 5'd16, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL half_len16 got e%b len%0d half%b addr%0d required e0 len16 half1 addr0",
                     a_empty, a_len, a_half, a_addr);
        end
        fiford = 1'b1;
        tick(8);
        fiford = 1'b0;
        #1;
        checks++;
        if ({a_len, a_half, a_addr} !== {5'd8, 1'b1, 4'd8}) begin
            errors++;
            $display("FAIL half_len8 got len%0d half%b addr%0d required len8 half1 addr8", a_len, a_half, a_addr);
        end
        fiford = 1'b1;
        tick(1);
        fiford = 1'b0;
        #1;
        checks++;
        if ({a_len, a_half} !== {5'd7, 1'b0}) begin
            errors++;
            $display("FAIL half_len7 got len%0d half%b required len7 half0", a_len, a_half);
        end
    endtask

    task automatic test_wrap;
        wrpnt_gray = 5'b10000;          // binary 31
        tick(2);
        checks++;
        if (a_len !== 5'd22) begin
            errors++;
            $display("FAIL wrap_len22 got %0d required 22", a_len);
        end
        fiford = 1'b1;
        tick(22);
        fiford = 1'b0;
        #1;
        checks++;
        if ({a_empty, a_addr} !== {1'b1, 4'd15}) begin
            errors++;
            $display("FAIL wrap_at31 got e%b addr%0d required e1 addr15", a_empty, a_addr);
        end
        wrpnt_gray = 5'b00000;          // binary 0 -> one entry past 31
        tick(2);
        checks++;
        if ({a_empty, a_len, a_addr, a_rgray} !== {1'b0, 5'd1, 4'd15, 5'b10000}) begin
            errors++;
            $display("FAIL wrap_pre got e%b len%0d addr%0d g%b required e0 len1 addr15 g10000",
                     a_empty, a_len, a_addr, a_rgray);
        end
        fiford = 1'b1;
        #1;
        checks++;
        if (a_read !== 1'b1) begin
            errors++;
            $display("FAIL wrap_read got %b required 1", a_read);
        end
        tick(1);
        fiford = 1'b0;
        #1;
        checks++;
        if ({a_empty, a_len, a_addr, a_rgray} !== {1'b1, 5'd0, 4'd0, 5'b10000}) begin
            errors++;
            $display("FAIL wrap_post got e%b len%0d addr%0d g%b required e1 len0 addr0 g10000",
                     a_empty, a_len, a_addr, a_rgray);
        end
        tick(1);
        checks++;
        if (a_rgray !== 5'b00000) begin
            errors++;
            $display("FAIL wrap_gray got %b required 00000", a_rgray);
        end
    endtask

    task automatic test_flush;
        wrpnt_gray = 5'b01100;          // binary 8, read pointer at 0
        tick(2);
        fiford = 1'b1;
        tick(2);
        checks++;
        if ({b_rdvld, b_addr} !== {1'b0, 4'd2}) begin
            errors++;
            $display("FAIL flush_lat2 got v%b addr%0d required v0 addr2", b_rdvld, b_addr);
        end
        tick(1);
        checks++;
        if ({b_rdvld, a_rdvld, a_read, a_addr} !== {1'b1, 1'b1, 1'b1, 4'd3}) begin
            errors++;
            $display("FAIL flush_pipefull got bv%b av%b r%b addr%0d required bv1 av1 r1 addr3",
                     b_rdvld, a_rdvld, a_read, a_addr);
        end
        fifoflush = 1'b1;
        #1;
        checks++;
        if ({a_read, b_read} !== 2'b00) begin
            errors++;
            $display("FAIL flush_read got a%b b%b required 00", a_read, b_read);
        end
        tick(1);
        fifoflush = 1'b0;
        fiford = 1'b0;
        #1;
        checks++;
        if ({b_addr, b_rdvld, a_rdvld, a_len, a_empty} !== {4'd0, 1'b0, 1'b0, 5'd8, 1'b0}) begin
            errors++;
            $display("FAIL flush_after got addr%0d bv%b av%b len%0d e%b required addr0 bv0 av0 len8 e0",
                     b_addr, b_rdvld, a_rdvld, a_len, a_empty);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checks++;
            if (b_rdvld !== 1'b0) begin
                errors++;
                $display("FAIL flush_stage%0d got rdvld=%b required 0", k, b_rdvld);
            end
        end
    endtask

    task automatic test_fshw3_and_reset;
        c_wgray = 5'b00001;             // binary 1
        tick(2);
        checks++;
        if (c_empty !== 1'b1) begin
            errors++;
            $display("FAIL fshw3_edge2 got empty=%b required 1", c_empty);
        end
        tick(1);
        checks++;
        if ({c_empty, c_len} !== {1'b0, 5'd1}) begin
            errors++;
            $display("FAIL fshw3_edge3 got e%b len%0d required e0 len1", c_empty, c_len);
        end
        c_wgray = 5'b01100;             // binary 8
        tick(3);
        c_fiford = 1'b1;
        tick(2);
        checks++;
        if ({c_rdvld, c_read, c_addr} !== {1'b1, 1'b1, 4'd2}) begin
            errors++;
            $display("FAIL fshw3_burst got v%b r%b addr%0d required v1 r1 addr2", c_rdvld, c_read, c_addr);
        end
        c_rst_ = 1'b0;
        tick(1);
        checks++;
        if ({c_empty, c_notempty, c_half, c_read, c_rdvld, c_len, c_addr, c_rgray}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 5'd0}) begin
            errors++;
            $display("FAIL fshw3_reset got e%b ne%b h%b r%b v%b len%0d addr%0d g%b required all reset values",
                     c_empty, c_notempty, c_half, c_read, c_rdvld, c_len, c_addr, c_rgray);
        end
        c_rst_ = 1'b1;
        c_fiford = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checks++;
            if (c_rdvld !== 1'b0) begin
                errors++;
                $display("FAIL fshw3_stale%0d got rdvld=%b required 0", k, c_rdvld);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_read();
        test_half_full();
        test_wrap();
        test_flush();
        test_fshw3_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
